// File: rtl/gnn_result_collector.sv
// Collects the eight ready-qualified GNN results into a frame buffer, then streams them out.
// Optional macro GNN_COLLECT_SAT_EN: saturate each word to OUT_W bits on capture and add sat_flag.
module gnn_result_collector #(
  parameter int DATA_W      = 21,
  parameter int TIMEOUT_CYC = 64,
  parameter int OUT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [8*DATA_W-1:0]      res_data,
  input  logic [7:0]               res_ready,
  output logic                     m_valid,
  input  logic                     m_ready,
`ifdef GNN_COLLECT_SAT_EN
  output logic signed [OUT_W-1:0]  m_data,
  output logic                     sat_flag,
`else
  output logic signed [DATA_W-1:0] m_data,
`endif
  output logic [2:0]               m_idx,
  output logic                     m_last,
  output logic                     frame_done,
  output logic                     timeout_err,
  output logic                     overrun_err,
  input  logic                     err_clr
);

  typedef enum logic {COLLECT = 1'b0, SEND = 1'b1} state_e;

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);
`ifdef GNN_COLLECT_SAT_EN
  localparam int BW = OUT_W;
`else
  localparam int BW = DATA_W;
`endif
  localparam logic signed [DATA_W-1:0] SAT_MAX = DATA_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [DATA_W-1:0] SAT_MIN = ~SAT_MAX;

  function automatic logic signed [OUT_W-1:0] sat_word(input logic signed [DATA_W-1:0] x);
    if (x > SAT_MAX) return SAT_MAX[OUT_W-1:0];
    if (x < SAT_MIN) return SAT_MIN[OUT_W-1:0];
    return x[OUT_W-1:0];
  endfunction

  function automatic logic clipped(input logic signed [DATA_W-1:0] x);
    return (x > SAT_MAX) || (x < SAT_MIN);
  endfunction

  function automatic logic signed [BW-1:0] cap_word(input logic signed [DATA_W-1:0] x);
`ifdef GNN_COLLECT_SAT_EN
    return sat_word(x);
`else
    return x;
`endif
  endfunction

  state_e                state_q, state_d;
  logic [7:0]            rdy_prev_q, mask_q, mask_d, mask_new, cap;
  logic signed [BW-1:0]  buf_q [8];
  logic signed [BW-1:0]  buf_d [8];
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            idx_q, idx_d;
  logic                  m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic signed [BW-1:0]  m_data_q, m_data_d;
  logic [2:0]            m_idx_q, m_idx_d;
  logic                  frame_done_q, frame_done_d;
  logic                  timeout_err_q, timeout_err_d, overrun_err_q, overrun_err_d;
  logic                  timeout_set, overrun_set;
`ifdef GNN_COLLECT_SAT_EN
  logic [7:0]            sat_q, sat_d;
  logic                  sat_flag_q, sat_flag_d;
`endif

  // Rising-edge detect: a held-high ready level captures only once.
  assign cap = res_ready & ~rdy_prev_q;

  always_comb begin
    state_d      = state_q;
    mask_new     = mask_q | cap;
    mask_d       = mask_q;
    buf_d        = buf_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    frame_done_d = 1'b0;
    timeout_set  = 1'b0;
    overrun_set  = 1'b0;
`ifdef GNN_COLLECT_SAT_EN
    sat_d        = sat_q;
`endif
    case (state_q)
      COLLECT: begin
        for (int k = 0; k < 8; k++) begin
          if (cap[k]) begin
            buf_d[k] = cap_word(res_data[k*DATA_W +: DATA_W]);
`ifdef GNN_COLLECT_SAT_EN
            sat_d[k] = clipped(res_data[k*DATA_W +: DATA_W]);
`endif
          end
        end
        // Completion outranks a timeout landing in the same cycle.
        if (mask_new == 8'hFF) begin
          state_d = SEND;
          mask_d  = mask_new;
          idx_d   = 3'd0;
          cnt_d   = '0;
        end else if (mask_q == 8'h00) begin
          mask_d = mask_new;
          cnt_d  = '0;
        end else if (cnt_q == CNT_MAX) begin
          mask_d      = 8'h00;
          cnt_d       = '0;
          timeout_set = 1'b1;
        end else begin
          mask_d = mask_new;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      SEND: begin
        overrun_set = |cap;
        if (m_valid_q && m_ready) begin
          if (idx_q == 3'd7) begin
            state_d      = COLLECT;
            mask_d       = 8'h00;
            idx_d        = 3'd0;
            frame_done_d = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = COLLECT;
    endcase

    // Output words are registered from the next-state view so SEND shows idx 0 one cycle after completion.
    m_valid_d     = (state_d == SEND);
    m_data_d      = m_valid_d ? buf_d[idx_d] : '0;
    m_idx_d       = m_valid_d ? idx_d : 3'd0;
    m_last_d      = m_valid_d && (idx_d == 3'd7);
    timeout_err_d = timeout_set | (timeout_err_q & ~err_clr);
    overrun_err_d = overrun_set | (overrun_err_q & ~err_clr);
`ifdef GNN_COLLECT_SAT_EN
    sat_flag_d    = m_valid_d && sat_d[idx_d];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= COLLECT;
      rdy_prev_q    <= 8'h00;
      mask_q        <= 8'h00;
      for (int k = 0; k < 8; k++) buf_q[k] <= '0;
      cnt_q         <= '0;
      idx_q         <= 3'd0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      m_idx_q       <= 3'd0;
      m_last_q      <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
`ifdef GNN_COLLECT_SAT_EN
      sat_q         <= 8'h00;
      sat_flag_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      rdy_prev_q    <= res_ready;
      mask_q        <= mask_d;
      buf_q         <= buf_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      m_idx_q       <= m_idx_d;
      m_last_q      <= m_last_d;
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
      overrun_err_q <= overrun_err_d;
`ifdef GNN_COLLECT_SAT_EN
      sat_q         <= sat_d;
      sat_flag_q    <= sat_flag_d;
`endif
    end
  end

  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign m_idx       = m_idx_q;
  assign m_last      = m_last_q;
  assign frame_done  = frame_done_q;
  assign timeout_err = timeout_err_q;
  assign overrun_err = overrun_err_q;
`ifdef GNN_COLLECT_SAT_EN
  assign sat_flag    = sat_flag_q;
`endif

endmodule

// File: tb/tb_gnn_result_collector.sv
// Randomized bench for gnn_result_collector with a frame-level reference model.
module tb_gnn_result_collector;
  localparam int DW = 21;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [8*DW-1:0] res_data = '0;
  logic [7:0]      res_ready = 8'h00;
  logic            m_ready = 1'b0;
  logic            err_clr = 1'b0;
  logic            m_valid;
`ifdef GNN_COLLECT_SAT_EN
  logic signed [15:0] m_data;
  logic               sat_flag;
  logic               got_sat [8];
`else
  logic signed [DW-1:0] m_data;
`endif
  logic [2:0] m_idx;
  logic       m_last, frame_done, timeout_err, overrun_err;

  int errors = 0;
  int checks = 0;
  logic signed [DW-1:0] model    [8];
  logic signed [DW-1:0] got_data [8];
  logic [2:0]           got_idx  [8];
  logic                 got_last [8];
  int n_got, fd_cnt, stall_bad, extra_valid;

  gnn_result_collector #(.DATA_W(DW), .TIMEOUT_CYC(TO), .OUT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .res_data(res_data), .res_ready(res_ready),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
`ifdef GNN_COLLECT_SAT_EN
    .sat_flag(sat_flag),
`endif
    .m_idx(m_idx), .m_last(m_last), .frame_done(frame_done),
    .timeout_err(timeout_err), .overrun_err(overrun_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  // Expected stream word for a captured input value.
  function automatic logic signed [DW-1:0] exp_word(input logic signed [DW-1:0] v);
`ifdef GNN_COLLECT_SAT_EN
    if (v > DW'(32767)) return DW'(32767);
    if (v < DW'(-32768)) return DW'(-32768);
`endif
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int k, input logic signed [DW-1:0] v);
    res_data[k*DW +: DW] = v;
  endtask

  task automatic load_random(input logic [7:0] which);
    logic signed [DW-1:0] v;
    for (int k = 0; k < 8; k++) begin
      if (which[k]) begin
        v = DW'($urandom());
        set_slot(k, v);
        model[k] = exp_word(v);
      end
    end
  endtask

  // Monitor: accepts up to 8 words, records them, and counts stall instability and frame_done pulses.
  task automatic drain(input bit toggle, input int budget);
    logic signed [DW-1:0] pd;
    logic [2:0] pi;
    logic pl;
    bit stalled;
    n_got = 0; fd_cnt = 0; stall_bad = 0; extra_valid = 0;
    for (int k = 0; k < 8; k++) begin
      got_data[k] = 'x; got_idx[k] = 'x; got_last[k] = 1'bx;
    end
    for (int c = 0; c < budget && n_got < 8; c++) begin
      m_ready = toggle ? (c % 2 == 0) : 1'b1;
      if (m_valid === 1'b1 && m_ready) begin
        got_data[n_got] = m_data;
        got_idx[n_got]  = m_idx;
        got_last[n_got] = m_last;
`ifdef GNN_COLLECT_SAT_EN
        got_sat[n_got]  = sat_flag;
`endif
        n_got++;
      end
      stalled = (m_valid === 1'b1) && !m_ready;
      pd = m_data; pi = m_idx; pl = m_last;
      tick();
      if (stalled && (m_data !== pd || m_idx !== pi || m_last !== pl || m_valid !== 1'b1)) stall_bad++;
      if (frame_done === 1'b1) fd_cnt++;
    end
    m_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (frame_done === 1'b1) fd_cnt++;
      if (m_valid === 1'b1) extra_valid++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; res_ready = 8'h00; m_ready = 1'b0;
    tick(); tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %0b expected 0", m_valid); end
    checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_m_data: got %0d expected 0", m_data); end
    checks++; if (m_idx !== 3'd0) begin errors++; $display("FAIL reset_m_idx: got %0d expected 0", m_idx); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %0b expected 0", m_last); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %0b expected 0", frame_done); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %0b expected 0", timeout_err); end
    checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL reset_overrun_err: got %0b expected 0", overrun_err); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_frame();
    logic signed [DW-1:0] v;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 8; k++) begin
        v = (r == 0) ? DW'(k * 1000 - 3000) : DW'($urandom());
        set_slot(k, v);
        model[k] = exp_word(v);
      end
      m_ready = 1'b1; res_ready = 8'hFF;
      tick();
      res_ready = 8'h00;
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: m_valid got %0b expected 1", m_valid); end
      drain(1'b0, 20);
      checks++; if (n_got !== 8) begin errors++; $display("FAIL basic_count: got %0d words expected 8", n_got); end
      for (int k = 0; k < 8; k++) begin
        checks++; if (got_data[k] !== model[k]) begin errors++; $display("FAIL basic_data[%0d]: got %0d expected %0d", k, got_data[k], model[k]); end
        checks++; if (got_idx[k] !== 3'(k)) begin errors++; $display("FAIL basic_idx[%0d]: got %0d expected %0d", k, got_idx[k], k); end
        checks++; if (got_last[k] !== (k == 7)) begin errors++; $display("FAIL basic_last[%0d]: got %0b expected %0b", k, got_last[k], (k == 7)); end
      end
      checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL basic_frame_done: got %0d pulses expected 1", fd_cnt); end
      checks++; if (extra_valid !== 0) begin errors++; $display("FAIL basic_trailing_valid: got %0d expected 0", extra_valid); end
    end
  endtask

  task automatic test_staggered();
    int order [9] = '{7, 0, 3, 4, 5, 6, 7, 1, 2};
    logic signed [DW-1:0] v;
    load_random(8'hFF);
    set_slot(2, DW'(-1));
    model[2] = exp_word(DW'(-1));
    for (int i = 0; i < 9; i++) begin
      if (i == 6) begin
        v = DW'($urandom());
        set_slot(7, v);
        model[7] = exp_word(v);
      end
      res_ready = 8'(1 << order[i]);
      tick();
      if (i < 8) begin
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL stagger_early_valid[%0d]: got %0b expected 0", i, m_valid); end
      end
    end
    res_ready = 8'h00;
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL stagger_latency: m_valid got %0b expected 1", m_valid); end
    drain(1'b1, 40);
    checks++; if (n_got !== 8) begin errors++; $display("FAIL stagger_count: got %0d words expected 8", n_got); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (got_data[k] !== model[k] || got_idx[k] !== 3'(k)) begin
        errors++; $display("FAIL stagger_word[%0d]: got %0d idx %0d expected %0d idx %0d", k, got_data[k], got_idx[k], model[k], k);
      end
    end
    checks++; if (got_data[2] !== DW'(-1)) begin errors++; $display("FAIL stagger_slot2: got %0d expected -1", got_data[2]); end
    checks++; if (stall_bad !== 0) begin errors++; $display("FAIL stagger_stall_stable: got %0d changes expected 0", stall_bad); end
    checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL stagger_frame_done: got %0d expected 1", fd_cnt); end
    checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL stagger_overrun: got %0b expected 0", overrun_err); end
  endtask

  task automatic test_timeout();
    int bad = 0;
    load_random(8'hFF);
    res_ready = 8'h7F;
    tick();
    res_ready = 8'h00;
    for (int c = 0; c < TO - 1; c++) begin
      tick();
      if (m_valid !== 1'b0) bad++;
    end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_early: got %0b expected 0", timeout_err); end
    tick();
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_set: got %0b expected 1", timeout_err); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL timeout_valid: got %0d valid cycles expected 0", bad); end
    res_ready = 8'h80;
    tick();
    res_ready = 8'h00;
    tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL timeout_mask_cleared: m_valid got %0b expected 0", m_valid); end
    load_random(8'h7F);
    res_ready = 8'h7F;
    tick();
    res_ready = 8'h00;
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL timeout_refill: m_valid got %0b expected 1", m_valid); end
    drain(1'b0, 20);
    for (int k = 0; k < 8; k++) begin
      checks++; if (got_data[k] !== model[k]) begin errors++; $display("FAIL timeout_word[%0d]: got %0d expected %0d", k, got_data[k], model[k]); end
    end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %0b expected 1", timeout_err); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %0b expected 0", timeout_err); end
  endtask

  task automatic test_overrun();
    logic signed [DW-1:0] v4;
    load_random(8'hFF);
    m_ready = 1'b0; res_ready = 8'hFF;
    tick();
    res_ready = 8'h00;
    tick(); tick();
    checks++; if (overrun_err !== 1'b0 || m_valid !== 1'b1 || m_idx !== 3'd0) begin
      errors++; $display("FAIL overrun_pre: err %0b valid %0b idx %0d expected 0 1 0", overrun_err, m_valid, m_idx);
    end
    v4 = DW'($urandom());
    set_slot(4, v4);
    res_ready = 8'h10;
    tick();
    checks++; if (overrun_err !== 1'b1) begin errors++; $display("FAIL overrun_set: got %0b expected 1", overrun_err); end
    drain(1'b0, 20);
    for (int k = 0; k < 8; k++) begin
      checks++; if (got_data[k] !== model[k]) begin errors++; $display("FAIL overrun_frame[%0d]: got %0d expected %0d", k, got_data[k], model[k]); end
    end
    res_ready = 8'hFF;
    tick(); tick(); tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL overrun_no_recapture: m_valid got %0b expected 0", m_valid); end
    res_ready = 8'hEF;
    tick();
    model[4] = exp_word(v4);
    res_ready = 8'hFF;
    tick();
    res_ready = 8'h00;
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL overrun_new_edge: m_valid got %0b expected 1", m_valid); end
    drain(1'b0, 20);
    for (int k = 0; k < 8; k++) begin
      checks++; if (got_data[k] !== model[k]) begin errors++; $display("FAIL overrun_next[%0d]: got %0d expected %0d", k, got_data[k], model[k]); end
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %0b expected 0", overrun_err); end
  endtask

  task automatic test_reset_mid_send();
    int late = 0;
    load_random(8'hFF);
    m_ready = 1'b1; res_ready = 8'hFF;
    tick();
    res_ready = 8'h00;
    tick(); tick(); tick(); tick();
    checks++; if (m_idx !== 3'd4) begin errors++; $display("FAIL rstmid_progress: idx got %0d expected 4", m_idx); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if ({m_valid, m_idx, m_last, frame_done} !== 6'd0 || m_data !== '0) begin
      errors++; $display("FAIL rstmid_outputs: valid %0b data %0d idx %0d last %0b done %0b expected all 0", m_valid, m_data, m_idx, m_last, frame_done);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (frame_done !== 1'b0 || m_valid !== 1'b0) late++;
    end
    checks++; if (late !== 0) begin errors++; $display("FAIL rstmid_quiet: got %0d active cycles expected 0", late); end
    load_random(8'hFF);
    res_ready = 8'hFF;
    tick();
    res_ready = 8'h00;
    drain(1'b0, 20);
    for (int k = 0; k < 8; k++) begin
      checks++; if (got_data[k] !== model[k] || got_idx[k] !== 3'(k)) begin
        errors++; $display("FAIL rstmid_next[%0d]: got %0d idx %0d expected %0d idx %0d", k, got_data[k], got_idx[k], model[k], k);
      end
    end
  endtask

  task automatic test_back_to_back();
    int held = 0;
    for (int f = 0; f < 2; f++) begin
      load_random(8'hFF);
      res_ready = 8'hFF;
      tick();
      if (f == 0) res_ready = 8'h00;
      drain(1'b0, 20);
      checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL b2b_frame_done[%0d]: got %0d expected 1", f, fd_cnt); end
      for (int k = 0; k < 8; k++) begin
        checks++; if (got_data[k] !== model[k]) begin errors++; $display("FAIL b2b_word[%0d][%0d]: got %0d expected %0d", f, k, got_data[k], model[k]); end
      end
    end
    for (int c = 0; c < 12; c++) begin
      tick();
      if (m_valid !== 1'b0) held++;
    end
    checks++; if (held !== 0) begin errors++; $display("FAIL b2b_level_once: got %0d valid cycles expected 0", held); end
    res_ready = 8'h00;
    tick();
  endtask

`ifdef GNN_COLLECT_SAT_EN
  task automatic test_saturation();
    res_data = '0;
    set_slot(0, DW'(40000));
    set_slot(1, DW'(-40000));
    set_slot(2, DW'(1234));
    res_ready = 8'hFF;
    tick();
    res_ready = 8'h00;
    drain(1'b0, 20);
    checks++; if (got_data[0] !== DW'(32767) || got_sat[0] !== 1'b1) begin errors++; $display("FAIL sat_pos: got %0d flag %0b expected 32767 1", got_data[0], got_sat[0]); end
    checks++; if (got_data[1] !== DW'(-32768) || got_sat[1] !== 1'b1) begin errors++; $display("FAIL sat_neg: got %0d flag %0b expected -32768 1", got_data[1], got_sat[1]); end
    checks++; if (got_data[2] !== DW'(1234) || got_sat[2] !== 1'b0) begin errors++; $display("FAIL sat_pass: got %0d flag %0b expected 1234 0", got_data[2], got_sat[2]); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_staggered();
    test_timeout();
    test_overrun();
    test_reset_mid_send();
    test_back_to_back();
`ifdef GNN_COLLECT_SAT_EN
    test_saturation();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
